// File: rtl/banked_mem.sv
// Two-port word-interleaved banked scratchpad with byte-enable writes,
// a fixed-latency read pipeline per port and anti-starvation bank arbitration.
module banked_mem #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned NUM_BANKS  = 4,
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_W-1:0]     a_addr,
   input  logic [DATA_W-1:0]     a_wdata,
   input  logic [DATA_W/8-1:0]   a_be,
   output logic                  a_gnt,
   output logic                  a_rvalid,
   output logic [DATA_W-1:0]     a_rdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_W-1:0]     b_addr,
   input  logic [DATA_W-1:0]     b_wdata,
   input  logic [DATA_W/8-1:0]   b_be,
   output logic                  b_gnt,
   output logic                  b_rvalid,
   output logic [DATA_W-1:0]     b_rdata
);

   localparam int unsigned BE_W     = DATA_W / 8;
   localparam int unsigned BANK_LOG = $clog2(NUM_BANKS);
   localparam int unsigned BANK_W   = (BANK_LOG > 0) ? BANK_LOG : 1;
   localparam int unsigned ROW_W    = (ADDR_W > BANK_LOG) ? ADDR_W - BANK_LOG : 1;
   localparam int unsigned ROWS     = (2 ** ADDR_W) / NUM_BANKS;
   localparam int unsigned CNT_W    = $clog2(STARVE_LIM + 1);

   // Low address bits pick the bank so consecutive words land in different banks.
   function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
      if (NUM_BANKS > 1) return addr[BANK_W-1:0];
      else               return '0;
   endfunction

   function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] addr);
      return ROW_W'(addr >> BANK_LOG);
   endfunction

   logic [DATA_W-1:0] mem [NUM_BANKS][ROWS];

   logic [BANK_W-1:0] a_bank, b_bank;
   logic [ROW_W-1:0]  a_row, b_row;
   logic              conflict;
   logic              boost;
   logic [CNT_W-1:0]  starve_cnt;
   logic              a_wr, a_rd, b_wr, b_rd;

   logic              a_v1, a_v2, b_v1, b_v2;
   logic [DATA_W-1:0] a_d1, a_d2, b_d1, b_d2;

   assign a_bank   = bank_of(a_addr);
   assign b_bank   = bank_of(b_addr);
   assign a_row    = row_of(a_addr);
   assign b_row    = row_of(b_addr);
   assign conflict = a_req && b_req && (a_bank == b_bank);
   assign boost    = (starve_cnt == CNT_W'(STARVE_LIM));

   // Bank arbitration: A wins a shared bank unless B has been starved long enough.
   always_comb begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      if (!rst) begin
         if (conflict) begin
            if (boost) b_gnt = 1'b1;
            else       a_gnt = 1'b1;
         end else begin
            a_gnt = a_req;
            b_gnt = b_req;
         end
      end
   end

   assign a_wr = a_req && a_gnt && a_we;
   assign a_rd = a_req && a_gnt && !a_we;
   assign b_wr = b_req && b_gnt && b_we;
   assign b_rd = b_req && b_gnt && !b_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!b_req || b_gnt) begin
         starve_cnt <= '0;
      end else if (!boost) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

   // Both ports never hit the same bank in one cycle, so their writes are disjoint.
   always_ff @(posedge clk) begin
      for (int i = 0; i < BE_W; i++) begin
         if (a_wr && a_be[i]) mem[a_bank][a_row][8*i +: 8] <= a_wdata[8*i +: 8];
         if (b_wr && b_be[i]) mem[b_bank][b_row][8*i +: 8] <= b_wdata[8*i +: 8];
      end
   end

   // Port A read pipeline: array read, stage 1, stage 2 drives rdata/rvalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_v1     <= 1'b0;
         a_v2     <= 1'b0;
         a_d1     <= '0;
         a_d2     <= '0;
         a_rvalid <= 1'b0;
         a_rdata  <= '0;
      end else begin
         a_v1     <= a_rd;
         a_v2     <= a_v1;
         a_rvalid <= a_v2;
         if (a_rd) a_d1    <= mem[a_bank][a_row];
         if (a_v1) a_d2    <= a_d1;
         if (a_v2) a_rdata <= a_d2;
      end
   end

   // Port B read pipeline, identical structure.
   always_ff @(posedge clk) begin
      if (rst) begin
         b_v1     <= 1'b0;
         b_v2     <= 1'b0;
         b_d1     <= '0;
         b_d2     <= '0;
         b_rvalid <= 1'b0;
         b_rdata  <= '0;
      end else begin
         b_v1     <= b_rd;
         b_v2     <= b_v1;
         b_rvalid <= b_v2;
         if (b_rd) b_d1    <= mem[b_bank][b_row];
         if (b_v1) b_d2    <= b_d1;
         if (b_v2) b_rdata <= b_d2;
      end
   end

endmodule

// File: tb/tb_banked_mem.sv
// Directed self-checking bench for banked_mem: sweep, byte enables, parallel
// banks, conflict/starvation sequence and mid-read reset.
module tb_banked_mem;

   logic        clk;
   logic        rst;
   logic        a_req, a_we, a_gnt, a_rvalid;
   logic [7:0]  a_addr;
   logic [31:0] a_wdata, a_rdata;
   logic [3:0]  a_be;
   logic        b_req, b_we, b_gnt, b_rvalid;
   logic [7:0]  b_addr;
   logic [31:0] b_wdata, b_rdata;
   logic [3:0]  b_be;

   banked_mem dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = w[8*i +: 8];
      return r;
   endfunction

   // Reference memory and expected-read queues with due cycle numbers.
   typedef struct {
      int          due;
      logic [31:0] data;
   } rd_t;

   logic [31:0] ref_mem [256];
   rd_t         qa[$];
   rd_t         qb[$];
   rd_t         ea, eb;
   int          cyc = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (a_rvalid) begin
         if (qa.size() == 0) check("a_rvalid_spurious", 64'(a_rvalid), 64'd0);
         else begin
            ea = qa.pop_front();
            check("a_rvalid_cycle", 64'(cyc), 64'(ea.due));
            check("a_rdata", 64'(a_rdata), 64'(ea.data));
         end
      end else if (qa.size() > 0 && qa[0].due <= cyc) begin
         void'(qa.pop_front());
         check("a_rvalid_missing", 64'(a_rvalid), 64'd1);
      end
      if (b_rvalid) begin
         if (qb.size() == 0) check("b_rvalid_spurious", 64'(b_rvalid), 64'd0);
         else begin
            eb = qb.pop_front();
            check("b_rvalid_cycle", 64'(cyc), 64'(eb.due));
            check("b_rdata", 64'(b_rdata), 64'(eb.data));
         end
      end else if (qb.size() > 0 && qb[0].due <= cyc) begin
         void'(qb.pop_front());
         check("b_rvalid_missing", 64'(b_rvalid), 64'd1);
      end
      if (rst) begin
         qa.delete();
         qb.delete();
      end else begin
         if (a_req && a_gnt && !a_we) qa.push_back('{cyc + 3, ref_mem[a_addr]});
         if (b_req && b_gnt && !b_we) qb.push_back('{cyc + 3, ref_mem[b_addr]});
         if (a_req && a_gnt && a_we) ref_mem[a_addr] = merge(ref_mem[a_addr], a_wdata, a_be);
         if (b_req && b_gnt && b_we) ref_mem[b_addr] = merge(ref_mem[b_addr], b_wdata, b_be);
      end
   end

   logic [31:0] exp4, exp20, exp30;

   initial begin
      rst = 1'b1;
      a_req = 1'b1; a_we = 1'b1; a_addr = 8'd0; a_wdata = 32'h1234_5678; a_be = 4'hF;
      b_req = 1'b1; b_we = 1'b1; b_addr = 8'd1; b_wdata = 32'h8765_4321; b_be = 4'hF;
      step();
      step();
      #2;
      check("rst_a_gnt", 64'(a_gnt), 64'd0);
      check("rst_b_gnt", 64'(b_gnt), 64'd0);
      check("rst_a_rvalid", 64'(a_rvalid), 64'd0);
      check("rst_b_rvalid", 64'(b_rvalid), 64'd0);
      check("rst_a_rdata", 64'(a_rdata), 64'd0);
      check("rst_b_rdata", 64'(b_rdata), 64'd0);
      step();
      rst = 1'b0;
      a_req = 1'b0;
      b_req = 1'b0;
      step();

      // Full write sweep then back-to-back read sweep on port A.
      for (int i = 0; i < 256; i++) begin
         a_req = 1'b1; a_we = 1'b1; a_addr = 8'(i); a_wdata = $urandom; a_be = 4'hF;
         step();
      end
      for (int i = 0; i < 256; i++) begin
         a_req = 1'b1; a_we = 1'b0; a_addr = 8'(i);
         step();
      end
      a_req = 1'b0;
      repeat (5) step();

      // Byte-enable merge on address 5.
      a_req = 1'b1; a_we = 1'b1; a_addr = 8'd5; a_wdata = 32'hAABB_CCDD; a_be = 4'hF;
      step();
      a_wdata = 32'h1122_3344; a_be = 4'b0101;
      step();
      a_we = 1'b0;
      step();
      a_req = 1'b0;
      step();
      step();
      check("be_rvalid", 64'(a_rvalid), 64'd1);
      check("be_rdata", 64'(a_rdata), 64'hAA22_CC44);
      step();

      // A reads bank 0 while B writes bank 1 in the same cycle.
      exp4 = ref_mem[4];
      a_req = 1'b1; a_we = 1'b0; a_addr = 8'd4;
      b_req = 1'b1; b_we = 1'b1; b_addr = 8'd1; b_wdata = 32'h0BAD_F00D; b_be = 4'hF;
      #2;
      check("par_a_gnt", 64'(a_gnt), 64'd1);
      check("par_b_gnt", 64'(b_gnt), 64'd1);
      step();
      a_req = 1'b0; b_req = 1'b0;
      step();
      step();
      check("par_a_rdata", 64'(a_rdata), 64'(exp4));
      b_req = 1'b1; b_we = 1'b0; b_addr = 8'd1;
      step();
      b_req = 1'b0;
      step();
      step();
      check("par_b_rdata", 64'(b_rdata), 64'h0BAD_F00D);
      step();

      // Persistent same-bank conflict: grants go A x4, B x1, repeating.
      a_req = 1'b1; a_we = 1'b0; a_addr = 8'd2;
      b_req = 1'b1; b_we = 1'b0; b_addr = 8'd6;
      for (int i = 0; i < 15; i++) begin
         #2;
         check($sformatf("conf_a_gnt%0d", i), 64'(a_gnt), 64'((i % 5) != 4));
         check($sformatf("conf_b_gnt%0d", i), 64'(b_gnt), 64'((i % 5) == 4));
         step();
      end
      a_req = 1'b0; b_req = 1'b0;
      repeat (5) step();

      // Reset one cycle after the last of three back-to-back reads.
      exp20 = ref_mem[20];
      exp30 = ref_mem[30];
      for (int i = 0; i < 3; i++) begin
         a_req = 1'b1; a_we = 1'b0; a_addr = 8'(20 + i);
         step();
      end
      a_req = 1'b0;
      rst = 1'b1;
      b_req = 1'b1; b_we = 1'b1; b_addr = 8'd30; b_wdata = 32'hDEAD_BEEF; b_be = 4'hF;
      #2;
      check("mid_rst_b_gnt", 64'(b_gnt), 64'd0);
      step();
      rst = 1'b0;
      b_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("mid_rst_rvalid%0d", i), 64'(a_rvalid), 64'd0);
         check($sformatf("mid_rst_rdata%0d", i), 64'(a_rdata), 64'd0);
         step();
      end
      a_req = 1'b1; a_we = 1'b0; a_addr = 8'd20;
      step();
      a_addr = 8'd30;
      step();
      a_req = 1'b0;
      check("post_rst_rv20", 64'(a_rvalid), 64'd0);
      step();
      check("post_rst_rd20", 64'(a_rdata), 64'(exp20));
      step();
      check("post_rst_rd30", 64'(a_rdata), 64'(exp30));
      repeat (4) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
